ocx_tlx_rand_throttle: RTL

- Stream pass-through stage that consumes the 8-bit pseudo-random byte from the TLX LFSR generator.
- Uses that byte to insert random-length stall windows on a valid/ready data path.
- Sits between a TLX producer (e.g. response or credit-return queue) and its consumer to exercise backpressure and bubble tolerance.
- Contains a 2-entry buffer so upstream flow control stays clean while stalls are injected downstream.

---
 rtl/ocx_tlx_rand_throttle.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ocx_tlx_rand_throttle.sv
// Valid/ready pass-through stage with a 2-entry buffer that injects random-length
// downstream stall windows driven by an LFSR byte, to exercise TLX backpressure.
module ocx_tlx_rand_throttle #(
    parameter int DATA_WIDTH = 64,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [7:0]            i_rand,
    input  logic                  i_cfg_enable,
    input  logic [7:0]            i_cfg_threshold,
    input  logic [3:0]            i_cfg_max_stall,
    input  logic                  i_in_valid,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_in_ready,
    output logic                  o_out_valid,
    output logic [DATA_WIDTH-1:0] o_out_data,
    input  logic                  i_out_ready,
    output logic                  o_stall_active,
    output logic [STAT_WIDTH-1:0] o_stall_count
);

    typedef enum logic {
        ST_PASS  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic [STAT_WIDTH-1:0] STAT_ONE = 1;

    function automatic logic [3:0] f_min4(input logic [3:0] a, input logic [3:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [STAT_WIDTH-1:0] f_sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + STAT_ONE;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    state_t                r_state;
    logic [3:0]            r_stall_cnt;
    logic [STAT_WIDTH-1:0] r_stall_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_decide;
    logic                  w_hit;
    logic [3:0]            w_len;

    assign o_in_ready     = (r_count != 2'd2);
    assign o_out_valid    = (r_state == ST_PASS) && (r_count != 2'd0);
    assign o_out_data     = r_mem[r_rd_ptr];
    assign o_stall_active = (r_state == ST_STALL);
    assign o_stall_count  = r_stall_count;

    assign w_push = i_in_valid & o_in_ready;
    assign w_pop  = o_out_valid & i_out_ready;

    // Decisions only when nothing is being offered or the offered word is leaving,
    // so a presented word is never withdrawn.
    assign w_decide = (r_state == ST_PASS) && ((r_count == 2'd0) || w_pop);
    assign w_hit    = i_cfg_enable && (i_rand < i_cfg_threshold);
    assign w_len    = f_min4(i_rand[3:0], i_cfg_max_stall);

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= ST_PASS;
            r_stall_cnt   <= 4'd0;
            r_stall_count <= '0;
        end else begin
            case (r_state)
                ST_PASS: begin
                    if (w_decide && w_hit) begin
                        r_state       <= ST_STALL;
                        r_stall_cnt   <= w_len;
                        r_stall_count <= f_sat_inc(r_stall_count);
                    end
                end
                ST_STALL: begin
                    // Dropping the enable aborts the window immediately.
                    if (!i_cfg_enable) begin
                        r_state     <= ST_PASS;
                        r_stall_cnt <= 4'd0;
                    end else if (r_stall_cnt == 4'd0) begin
                        r_state <= ST_PASS;
                    end else begin
                        r_stall_cnt <= r_stall_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state     <= ST_PASS;
                    r_stall_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule
